// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start/data/parity/stop framing with a
// single-entry held-frame handshake and overrun flagging.
module uart_rx_sequencer #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] parity_type,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [2:0] err_flags,
  output logic       busy
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HALF_M1  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Odd (01) flags an even total of ones, even (10) flags an odd total.
  function automatic logic parity_error(input logic [7:0] data, input logic p,
                                        input logic [1:0] ptype);
    logic x;
    x = ^{data, p};
    case (ptype)
      2'b01:   parity_error = ~x;
      2'b10:   parity_error = x;
      default: parity_error = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [1:0]  par_type_r, par_type_s;
  logic        par_err_r, par_err_s;
  logic        done_s;
  logic        stop_err_s;

  // Next-state and datapath decode; everything advances on baud_tick only.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    par_type_s = par_type_r;
    par_err_s  = par_err_r;
    done_s     = 1'b0;
    stop_err_s = 1'b0;
    if (baud_tick) begin
      case (state_r)
        IDLE: begin
          cnt_s = CNT_ZERO;
          if (!rx) begin
            state_s    = START;
            par_type_s = parity_type;
            bit_idx_s  = 3'd0;
            par_err_s  = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == HALF_M1) begin
            cnt_s   = CNT_ZERO;
            state_s = rx ? IDLE : DATA;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_s            = CNT_ZERO;
            shift_s[bit_idx_r] = rx;
            if (bit_idx_r == 3'd7) begin
              bit_idx_s = 3'd0;
              state_s   = (^par_type_r) ? PARITY : STOP;
            end else begin
              bit_idx_s = bit_idx_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        PARITY: begin
          if (cnt_r == FULL_M1) begin
            cnt_s     = CNT_ZERO;
            par_err_s = parity_error(shift_r, rx, par_type_r);
            state_s   = STOP;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_s      = CNT_ZERO;
            stop_err_s = ~rx;
            done_s     = 1'b1;
            state_s    = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and receive datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      par_type_r <= 2'b00;
      par_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      par_type_r <= par_type_s;
      par_err_r  <= par_err_s;
    end
  end

  // Held-frame output stage: a completion always wins over a transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out   <= 8'h00;
      err_flags  <= 3'b000;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      if (done_s) begin
        data_out   <= shift_r;
        err_flags  <= {data_valid & ~out_ready, stop_err_s, par_err_r & (^par_type_r)};
        data_valid <= 1'b1;
      end else if (data_valid && out_ready) begin
        data_valid   <= 1'b0;
        err_flags[2] <= 1'b0;
      end else begin
        data_valid <= data_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Self-checking bench for uart_rx_sequencer: directed frame table, corner
// sequences, and randomized frames against an arithmetic frame model.
module tb_uart_rx_sequencer;

  localparam int OVS = 16;

  logic       clk;
  logic       reset_n;
  logic       baud_tick;
  logic       rx;
  logic [1:0] parity_type;
  logic       out_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] err_flags;
  logic       busy;

  uart_rx_sequencer #(.OVS(OVS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .parity_type(parity_type),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err_flags  (err_flags),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] e;
  } xfer_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pt;
    logic       pbit;
    logic       stopbit;
    logic [2:0] exp_e;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  xfer_t got[$];
  logic  noise_en = 1'b0;
  logic  rdy_rand = 1'b0;
  logic  rdy_fixed = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer ready: fixed level or random per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rdy_rand ? 1'($urandom) : rdy_fixed;
    end
  end

  // Record every accepted frame (valid and ready both high before the edge).
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && data_valid && out_ready) got.push_back({data_out, err_flags});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hold the line at lvl for n ticks; non-tick cycles may carry noise.
  task automatic line_ticks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx        = lvl;
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
      rx        = noise_en ? 1'($urandom) : lvl;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] pt, input logic pbit,
                            input logic stopbit, input int extra);
    parity_type = pt;
    line_ticks(1'b0, OVS);
    parity_type = 2'($urandom);
    for (int i = 0; i < 8; i++) line_ticks(b[i], OVS);
    if (pt == 2'b01 || pt == 2'b10) line_ticks(pbit, OVS);
    line_ticks(stopbit, OVS);
    line_ticks(1'b1, OVS + extra);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] ed, input logic [2:0] ee);
    int    n;
    xfer_t x;
    n = 0;
    while (got.size() == 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (got.size() == 0) begin
      n_bad++;
      $display("FAIL %s_present: got no transfer expected data %02h", nm, ed);
    end else begin
      x = got.pop_front();
      chk({nm, "_data"}, 32'(x.d), 32'(ed));
      chk({nm, "_err"}, 32'(x.e), 32'(ee));
    end
  endtask

  // Frame model: parity rule from the count of ones, stop error when stop is 0.
  function automatic logic [2:0] model_err(input logic [7:0] b, input logic [1:0] pt,
                                           input logic pbit, input logic stopbit);
    int  ones;
    logic pe;
    ones = $countones(b) + (pbit ? 1 : 0);
    if (pt == 2'b01)      pe = (ones % 2 == 0);
    else if (pt == 2'b10) pe = (ones % 2 == 1);
    else                  pe = 1'b0;
    return {1'b0, ~stopbit, pe};
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 3'b000};
    vecs[1] = '{8'h03, 2'b10, 1'b1, 1'b1, 3'b001};
    vecs[2] = '{8'h03, 2'b10, 1'b0, 1'b1, 3'b000};
    vecs[3] = '{8'h00, 2'b01, 1'b1, 1'b0, 3'b010};
    vecs[4] = '{8'h5A, 2'b00, 1'b0, 1'b1, 3'b000};
    vecs[5] = '{8'hFF, 2'b01, 1'b0, 1'b1, 3'b001};
    vecs[6] = '{8'hFF, 2'b01, 1'b1, 1'b1, 3'b000};
    vecs[7] = '{8'h80, 2'b10, 1'b1, 1'b1, 3'b000};
    vecs[8] = '{8'h3C, 2'b11, 1'b1, 1'b0, 3'b010};
    vecs[9] = '{8'h01, 2'b10, 1'b0, 1'b0, 3'b011};

    reset_n     = 1'b0;
    baud_tick   = 1'b0;
    rx          = 1'b1;
    parity_type = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_err_flags", 32'(err_flags), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    line_ticks(1'b1, 4);

    // Directed frame table with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].d, vecs[i].pt, vecs[i].pbit, vecs[i].stopbit, 0);
      check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_e);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
      chk($sformatf("vec%0d_single", i), 32'(got.size()), 32'd0);
    end

    // Short glitch: START entered, then a false start with no output.
    line_ticks(1'b0, 4);
    chk("glitch_busy_high", 32'(busy), 32'h1);
    line_ticks(1'b1, 12);
    chk("glitch_busy_low", 32'(busy), 32'h0);
    chk("glitch_no_valid", 32'(data_valid), 32'h0);
    chk("glitch_no_xfer", 32'(got.size()), 32'd0);

    // Overrun: two frames with the consumer stalled.
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, 0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1, 0);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_err", 32'(err_flags), 32'h4);
    chk("ovr_no_xfer", 32'(got.size()), 32'd0);
    rdy_fixed = 1'b1;
    repeat (5) @(negedge clk);
    chk("ovr_one_xfer", 32'(got.size()), 32'd1);
    check_frame("ovr_xfer", 8'h22, 3'b100);
    chk("ovr_valid_clr", 32'(data_valid), 32'h0);

    // Reset during data bit 4, then a clean frame.
    parity_type = 2'b00;
    line_ticks(1'b0, OVS);
    for (int i = 0; i < 4; i++) line_ticks(1'b1, OVS);
    line_ticks(1'b0, OVS / 2);
    chk("mid_busy_before_rst", 32'(busy), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_data", 32'(data_out), 32'h00);
    chk("mid_rst_err", 32'(err_flags), 32'h0);
    reset_n = 1'b1;
    line_ticks(1'b1, OVS);
    chk("mid_no_partial", 32'(got.size()), 32'd0);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 0);
    check_frame("post_rst", 8'h7E, 3'b000);

    // Randomized frames, random consumer, noise between ticks.
    rdy_rand = 1'b1;
    noise_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic [1:0] pt;
      logic       pb;
      logic       sb;
      b  = 8'($urandom);
      pt = 2'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(b, pt, pb, sb, $urandom_range(0, 4));
      check_frame($sformatf("rnd%0d", i), b, model_err(b, pt, pb, sb));
    end
    noise_en = 1'b0;
    rdy_rand = 1'b0;
    line_ticks(1'b1, 4);
    chk("no_extra_xfer", 32'(got.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 Parameter OVS, default 16, baud_tick pulses per bit period; legal values are even and in 8..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 baud_tick  input  1  single-cycle oversampling strobe, OVS per bit.
REQ-005 rx  input  1  serial line, already synchronised, idle high.
REQ-006 parity_type  input  2  01 odd, 10 even, 00/11 no parity; sampled at start-bit detection.
REQ-007 out_ready  input  1  consumer accepts the held frame.
REQ-008 data_out  output  8  received byte, LSB first on the line.
REQ-009 data_valid  output  1  frame held for the consumer.
REQ-010 err_flags  output  3  [0] parity error, [1] stop error, [2] overrun; qualified by data_valid.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 States: IDLE, START, DATA, PARITY, STOP; all transitions occur on cycles with baud_tick=1 only.
REQ-013 Tick counter width is clog2(OVS); it resets to 0 on every state change and increments on each baud_tick.
REQ-014 IDLE: rx=0 on a baud_tick -> START, counter cleared, parity_type latched.
REQ-015 START: rx is sampled when counter reaches OVS/2-1; rx=1 -> IDLE as a false start with no output; rx=0 -> DATA, counter cleared.
REQ-016 Mid-bit alignment: each later bit is sampled when counter reaches OVS-1; bit index 0..7 shifts into data bit [index].
REQ-017 DATA: after bit 7 is sampled -> PARITY if latched parity_type is 01 or 10, else -> STOP.
REQ-018 PARITY: the sampled bit sets the parity error as follows: odd -> error when ^{data,p}=0; even -> error when ^{data,p}=1.
REQ-019 STOP: the sampled bit sets the stop error when it equals 0; the FSM then -> IDLE on the same tick and the frame completes.
REQ-020 No-parity frames force err_flags[0]=0.
REQ-021 Frame completion loads data_out and err_flags and sets data_valid=1 on the next clock edge.
REQ-022 Handshake: data_valid stays 1 and data_out/err_flags stay stable until a cycle with data_valid=1 and out_ready=1; data_valid clears on the following edge unless a completion occurs in that same cycle.
REQ-023 Completion in the same cycle as a transfer: the new frame loads, data_valid stays 1, and err_flags[2]=0.
REQ-024 Completion while data_valid=1 without a transfer: the new frame overwrites data_out and err_flags[1:0], and err_flags[2] is set to 1.
REQ-025 err_flags[2] stays set until the next transfer.
REQ-026 A stop error does not block reception; the next falling edge seen in IDLE starts a new frame.
REQ-027 rx changes between baud_ticks are ignored; only tick-cycle samples matter.

Reset
REQ-028 reset_n=0 at a clock edge forces state IDLE, counter 0, bit index 0, data_out=8'h00, err_flags=3'b000, data_valid=0, busy=0.
REQ-029 Reset mid-frame discards the partial frame; no data_valid is produced for it after release.
REQ-030 After release, reception requires a fresh falling edge seen in IDLE.

Verification
REQ-031 OVS=16, parity_type=00, out_ready=1, frame 0xA5 with stop bit 1 -> one data_valid pulse, data_out=8'hA5, err_flags=000, busy low after the stop bit.
REQ-032 parity_type=10, byte 0x03, parity bit 1 -> err_flags=001; the same frame with parity bit 0 -> err_flags=000.
REQ-033 parity_type=01, byte 0x00, parity bit 1, stop bit 0 -> err_flags=010; the next frame 0x5A is received correctly.
REQ-034 Glitch low on rx for 4 ticks in IDLE -> START, then IDLE, and no data_valid.
REQ-035 out_ready=0, two frames 0x11 then 0x22 -> data_out=8'h22, err_flags[2]=1; raise out_ready -> one transfer, then data_valid=0.
REQ-036 reset_n=0 during DATA bit 4, then release and send 0x7E -> only 0x7E is delivered, with err_flags=000.
